// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath constants.
// Only the register/address width is needed by the fetch stage.
// Purely declarative; no logic.
package riscv_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus between fetch_unit, instruction_memory and the decoder.
// Latency: none; the interface is just wires.
// Backpressure: none on this bus; stall is carried as a scalar beside it.
// Signals:
//   instruction  word returned by instruction_memory for pc_out
//   pc_out       current PC (to instruction_memory.pc_in and the decoder)
//   pc_plus4     pc_out + 4, link value for JAL/JALR
//   instr_out    instruction forwarded to the decoder
//   instr_valid  instr_out is being issued this cycle
// master = fetch_unit side, slave = memory/decoder side.
interface fetch_unit_if;
  logic [riscv_pkg::XLEN-1:0] instruction;
  logic [riscv_pkg::XLEN-1:0] pc_out;
  logic [riscv_pkg::XLEN-1:0] pc_plus4;
  logic [riscv_pkg::XLEN-1:0] instr_out;
  logic                       instr_valid;

  modport master (
    input  instruction,
    output pc_out,
    output pc_plus4,
    output instr_out,
    output instr_valid
  );

  modport slave (
    output instruction,
    input  pc_out,
    input  pc_plus4,
    input  instr_out,
    input  instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// PC register and fetch control: sequential advance, redirect, stall, halt/resume, misaligned-target trap.
// Latency: 0 cycles PC->instruction (instruction_memory is combinational); PC updates on each rising edge.
// Backpressure: stall holds the PC and drops instr_valid; an aligned redirect still flushes under stall.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   stall             hold PC, decoder not accepting
//   redirect_valid    branch/jump taken; redirect_pc is its target
//   halt_req, resume  enter / leave HALT (resume wins over halt_req in HALT)
//   fb                fetch bus (fetch_unit_if.master): instruction in; pc_out, pc_plus4,
//                     instr_out, instr_valid out
//   halted            block is in HALT
//   misalign_trap     one-cycle pulse, a redirect target was not word aligned
//   trap_pc           offending target, held until the next trap
//   fetch_count       64-bit issued-instruction counter, present only when the
//                     FETCH_COUNTER_EN macro is defined
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  input  logic            resume,
  fetch_unit_if.master    fb,
  output logic            halted,
  output logic            misalign_trap,
  output logic [XLEN-1:0] trap_pc
`ifdef FETCH_COUNTER_EN
  ,
  output logic [63:0]     fetch_count
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] trap_pc_q;
  logic [XLEN-1:0] trap_pc_d;
  logic            trap_q;
  logic            trap_d;
  logic [XLEN-1:0] pc_next_seq;
  logic            misaligned;
  logic            issue;

  // Natural wrap at 2^XLEN: 0xFFFF_FFFC + 4 = 0.
  assign pc_next_seq = pc_q + XLEN'(4);
  assign misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign issue       = (state_q == RUN) && !stall;

  // State and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      trap_pc_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_pc_q <= trap_pc_d;
      trap_q    <= trap_d;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    trap_d    = 1'b0;

    // A misaligned target never reaches the PC; it is captured for the trap
    // handler in any active state and always parks the block in HALT.
    if ((state_q != BOOT) && misaligned) begin
      trap_d    = 1'b1;
      trap_pc_d = redirect_pc;
    end

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (misaligned) begin
          state_d = HALT;
        end else if (redirect_valid) begin
          // Redirect flushes, so it is taken even while stalled.
          pc_d = redirect_pc;
        end else if (halt_req) begin
          state_d = HALT;
        end else if (!stall) begin
          pc_d = pc_next_seq;
        end
      end

      HALT: begin
        // stall has no effect here. An aligned redirect is the debugger's
        // PC write; a trap keeps the block halted even if resume is present.
        if (!misaligned) begin
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end
          if (resume) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign fb.pc_out      = pc_q;
  assign fb.pc_plus4    = pc_next_seq;
  assign fb.instr_out   = fb.instruction;
  assign fb.instr_valid = issue;
  assign halted         = (state_q == HALT);
  assign misalign_trap  = trap_q;
  assign trap_pc        = trap_pc_q;

`ifdef FETCH_COUNTER_EN
  logic [63:0] fetch_count_q;

  // Counts issued instructions; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else if (issue) begin
      fetch_count_q <= fetch_count_q + 64'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
